// File: rtl/jk_arb_pkg.sv
// Shared definitions for the JK bank arbiter: op encodings and FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package jk_arb_pkg;

  // {J,K} operation encodings
  localparam logic [1:0] JK_HOLD = 2'b00;
  localparam logic [1:0] JK_CLR  = 2'b01;
  localparam logic [1:0] JK_SET  = 2'b10;
  localparam logic [1:0] JK_TGL  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_APPLY = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

endpackage

// File: rtl/jk_cell.sv
// One JK storage bit; updates only on cycles where i_en is high.
// Latency: 1 cycle from enable to o_q.
// Backpressure: none; the cell always accepts an enabled op.
// Ports: i_clk, i_rstn (async, active-low, clears to 0), i_en, i_j, i_k, o_q.
module jk_cell
  import jk_arb_pkg::*;
(
  input  logic i_clk,
  input  logic i_rstn,
  input  logic i_en,
  input  logic i_j,
  input  logic i_k,
  output logic o_q
);

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      o_q <= 1'b0;
    end else if (i_en) begin
      case ({i_j, i_k})
        JK_CLR:  o_q <= 1'b0;
        JK_SET:  o_q <= 1'b1;
        JK_TGL:  o_q <= ~o_q;
        default: o_q <= o_q;
      endcase
    end
  end

endmodule

// File: rtl/jk_bank_arbiter.sv
// Arbitrates NUM_REQ requesters onto a bank of NUM_BITS JK cells, one op at a time.
// Latency: request seen in IDLE -> ack 2 cycles later; one op per 3 cycles.
// Backpressure: requesters hold i_req/i_jk/i_idx until o_ack; inputs sampled only in IDLE.
// Ports: i_clk, i_rstn (async, active-low), i_req[NUM_REQ], i_jk[2*NUM_REQ],
//        i_idx[IDX_W*NUM_REQ], o_gnt/o_ack[NUM_REQ], o_err, o_busy, o_q[NUM_BITS].
// Build option: JK_ARB_RR_EN selects round-robin; undefined gives fixed priority (req 0 highest).
module jk_bank_arbiter
  import jk_arb_pkg::*;
#(
  parameter  int NUM_REQ  = 4,
  parameter  int NUM_BITS = 8,
  localparam int IDX_W    = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [NUM_REQ-1:0]       i_req,
  input  logic [2*NUM_REQ-1:0]     i_jk,
  input  logic [IDX_W*NUM_REQ-1:0] i_idx,
  output logic [NUM_REQ-1:0]       o_gnt,
  output logic [NUM_REQ-1:0]       o_ack,
  output logic                     o_err,
  output logic                     o_busy,
  output logic [NUM_BITS-1:0]      o_q
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  // NUM_BITS never exceeds 2**IDX_W, so IDX_W+1 bits hold it exactly.
  localparam logic [IDX_W:0] NB = (IDX_W+1)'(NUM_BITS);

  state_t               state, state_nxt;
  logic [PTR_W-1:0]     ptr;
  logic                 sel_found;
  logic [PTR_W-1:0]     sel_win;
  logic [NUM_REQ-1:0]   sel_gnt;
  logic [1:0]           sel_jk;
  logic [IDX_W-1:0]     sel_idx;
  logic [1:0]           lat_jk;
  logic [IDX_W-1:0]     lat_idx;
  logic [NUM_REQ-1:0]   gnt_q;
  logic [NUM_BITS-1:0]  cell_en;

  // Rotating-priority pointer; pinned to 0 in the fixed-priority build.
`ifdef JK_ARB_RR_EN
  logic [PTR_W-1:0] win_q;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      win_q <= '0;
      ptr   <= '0;
    end else if (state == ST_IDLE && sel_found) begin
      win_q <= sel_win;
    end else if (state == ST_ACK) begin
      ptr <= (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);
    end
  end
`else
  assign ptr = '0;
`endif

  // Scan upward from ptr with wrap-around; first asserted request wins.
  always_comb begin
    int r;
    r         = 0;
    sel_found = 1'b0;
    sel_win   = '0;
    sel_gnt   = '0;
    sel_jk    = JK_HOLD;
    sel_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r = int'(ptr) + i;
      if (r >= NUM_REQ) r = r - NUM_REQ;
      if (!sel_found && i_req[r]) begin
        sel_found  = 1'b1;
        sel_win    = PTR_W'(r);
        sel_gnt[r] = 1'b1;
        sel_jk     = i_jk[2*r +: 2];
        sel_idx    = i_idx[IDX_W*r +: IDX_W];
      end
    end
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE:  state_nxt = sel_found ? ST_APPLY : ST_IDLE;
      ST_APPLY: state_nxt = ST_ACK;
      ST_ACK:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // FSM: outputs. An out-of-range index matches no cell, so nothing is written.
  always_comb begin
    o_busy = (state != ST_IDLE);
    o_ack  = (state == ST_ACK) ? gnt_q : '0;
    o_err  = (state == ST_ACK) && ({1'b0, lat_idx} >= NB);
    for (int b = 0; b < NUM_BITS; b++) begin
      cell_en[b] = (state == ST_APPLY) && (lat_idx == IDX_W'(b));
    end
  end

  // Winner's op is latched in IDLE so requester changes after grant are ignored.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      gnt_q   <= '0;
      lat_jk  <= JK_HOLD;
      lat_idx <= '0;
    end else if (state == ST_IDLE && sel_found) begin
      gnt_q   <= sel_gnt;
      lat_jk  <= sel_jk;
      lat_idx <= sel_idx;
    end else if (state == ST_ACK) begin
      gnt_q <= '0;
    end
  end

  assign o_gnt = gnt_q;

  for (genvar b = 0; b < NUM_BITS; b++) begin : g_cell
    jk_cell u_cell (
      .i_clk  (i_clk),
      .i_rstn (i_rstn),
      .i_en   (cell_en[b]),
      .i_j    (lat_jk[1]),
      .i_k    (lat_jk[0]),
      .o_q    (o_q[b])
    );
  end

endmodule

// File: doc/jk_bank_arbiter.md
# jk_bank_arbiter

Shared-access controller for a bank of JK storage cells. Arbitrates among `NUM_REQ` requesters, each issuing one JK operation (hold/clear/set/toggle) on one bit index at a time. Applies the winning operation to the addressed cell and returns a one-cycle acknowledge. It is the single write path into the JK bank; the bank contents are exported continuously on `o_q`.

## Interface
- `NUM_REQ`, 4: number of requesters, ≥1.
- `NUM_BITS`, 8: number of JK cells in the bank, ≥1.
- `IDX_W`, `$clog2(NUM_BITS)` (min 1): bit-index width per requester. Derived; not overridden.
- `i_clk` input 1: single clock, rising edge.
- `i_rstn` input 1: reset, asynchronous, active-low.
- `i_req` input NUM_REQ: per-requester request level.
- `i_jk` input 2*NUM_REQ: per-requester op `{J,K}`; requester r at bits `[2r+1:2r]`.
- `i_idx` input IDX_W*NUM_REQ: per-requester target bit; requester r at `[IDX_W*r +: IDX_W]`.
- `o_gnt` output NUM_REQ: one-hot grant, registered.
- `o_ack` output NUM_REQ: one-hot, one-cycle completion pulse.
- `o_err` output 1: one-cycle pulse coincident with `o_ack` when the latched index is ≥ NUM_BITS.
- `o_busy` output 1: high whenever the FSM is not in IDLE.
- `o_q` output NUM_BITS: current bank contents.

## Operation
- Reset values: `o_q`=0, `o_gnt`=0, `o_ack`=0, `o_err`=0, `o_busy`=0, FSM=IDLE, round-robin pointer=0. Reset is honoured in any state and aborts an in-flight op; the target bit is left at 0 like all others.
- FSM states: IDLE → APPLY → ACK → IDLE. No other transitions except reset.
- IDLE: if any `i_req` bit is high, select a winner, latch its `{J,K}` and index, set `o_gnt` to the winner, and go to APPLY. Otherwise stay in IDLE.
- APPLY: pulse the write enable of cell `idx` for this cycle only. The cell takes `00` hold, `01` clear, `10` set, `11` toggle. If `idx` ≥ NUM_BITS, no cell is enabled. Go to ACK.
- ACK: `o_ack[winner]`=1. `o_err`=1 if the index was out of range. The pointer moves to `(winner+1) mod NUM_REQ` (round-robin builds only). Go to IDLE, clearing `o_gnt`.
- Selection: scan from the pointer upward with wrap-around. The first asserted request wins.
- Inputs are sampled only in IDLE. Changes to `i_jk`/`i_idx`/`i_req` during APPLY or ACK have no effect.
- A requester that drops `i_req` after being granted still gets its op applied and acknowledged.
- Handshake: the requester holds `i_req`, `i_jk` and `i_idx` stable until it sees `o_ack`. If `i_req` is still high at the next IDLE sample, it is a new request.
- Multiple requesters on the same index are serialised. Each op sees the result of the previous one.

## Timing
- Edge E0 (IDLE, req seen): `o_gnt`, `o_busy` rise.
- Edge E1: `o_q[idx]` updates, `o_ack`/`o_err` rise.
- Edge E2: `o_gnt`, `o_ack`, `o_err`, `o_busy` fall.
- The earliest next grant is at E3.
- Latency: request in IDLE to acknowledge is 2 cycles. Throughput is 1 op per 3 cycles.
- `o_q` already shows the new value in the cycle `o_ack` is high.
- `o_gnt` is high for exactly 2 cycles per op. `o_ack` is high for exactly 1 cycle.

## Configuration
- `JK_ARB_RR_EN` defined: round-robin arbitration with a rotating pointer, as above.
- `JK_ARB_RR_EN` undefined: fixed priority. The lowest requester index always wins; the pointer logic is absent (constant 0).
- All other behaviour and timing are identical in both builds.

## Structure
- Package `jk_arb_pkg` holds:
  - Op encodings `JK_HOLD`=2'b00, `JK_CLR`=2'b01, `JK_SET`=2'b10, `JK_TGL`=2'b11.
  - FSM state typedef/localparams `ST_IDLE`, `ST_APPLY`, `ST_ACK`.
- Sub-module `jk_cell`: one JK bit with inputs clock, async active-low reset (to 0), enable, J, K. It holds its value when enable is low. It is instantiated NUM_BITS times via generate.
- The arbiter, latch registers and FSM live in the top module.

## Test plan
- Reset mid-op: assert `i_req[0]` with `{J,K}=10`, idx 3; pull `i_rstn` low in the APPLY cycle → `o_q`=0, no `o_ack`; after release the FSM is IDLE and `o_busy`=0.
- Single op timing: `i_req[1]`, `{J,K}=10`, idx 5 → `o_gnt`=0010 for 2 cycles; `o_ack`=0010 at E1; `o_q`=8'h20 at the same time.
- Toggle and clear on the same bit: set bit 2, toggle bit 2, toggle bit 2, clear bit 2 → `o_q[2]` reads 1, 0, 1, 0 after each ack.
- Contention: `i_req`=1111 held continuously, each requester re-requesting after its ack:
  - RR build: grants go 0,1,2,3,0.
  - Without `JK_ARB_RR_EN`: grants are always 0.
- Out-of-range index with NUM_BITS=6, idx 7, `{J,K}=10` → `o_ack` and `o_err` pulse together; `o_q` is unchanged.
- Withdrawn request: requester 2 drops `i_req` during APPLY → its op still completes and `o_ack[2]` pulses; no second grant is issued to it.
